// File: rtl/kernel_axis_rr_arbiter.sv
// kernel_axis_rr_arbiter: packet-granular round-robin arbiter sharing one kernel AXI-Stream input.
// Define KERNEL_AXIS_ARB_WATCHDOG_EN to build the sticky stall watchdog (wdog_stall).
module kernel_axis_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 64,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                          kernel_monitor_clock,
    input  logic                          kernel_monitor_reset,
    input  logic [NUM_SRC*DATA_W-1:0]     s_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0]   s_tkeep,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_W-1:0]             m_tdata,
    output logic [DATA_W/8-1:0]           m_tkeep,
    output logic                          m_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic [NUM_SRC-1:0]            src_block,
    output logic                          wdog_stall
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int KW = DATA_W / 8;
    localparam logic [GW:0] SRC_CNT = (GW + 1)'(NUM_SRC);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       grant_nxt;
    logic                found;
    logic [GW:0]         cand;
    logic [NUM_SRC-1:0]  shifted;
    logic [NUM_SRC-1:0]  grant_oh;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic [KW-1:0]       sel_keep;
    logic                can_load;
    logic                accept;

    // Round-robin scan starting one past the last source that finished a packet.
    always_comb begin
        found     = 1'b0;
        grant_nxt = grant_id;
        cand      = '0;
        shifted   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_grant} + (GW + 1)'(k);
            if (cand >= SRC_CNT) begin
                cand = cand - SRC_CNT;
            end
            shifted = s_tvalid >> cand;
            if (!found && shifted[0]) begin
                found     = 1'b1;
                grant_nxt = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == GW'(i)) begin
                grant_oh[i] = 1'b1;
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_data    = s_tdata[i*DATA_W +: DATA_W];
                sel_keep    = s_tkeep[i*KW +: KW];
            end
        end
    end

    assign can_load  = ~m_tvalid | m_tready;
    assign accept    = (state == XFER) & sel_valid & can_load;
    assign s_tready  = ((state == XFER) && can_load) ? grant_oh : '0;
    assign busy      = (state == XFER);
    assign src_block = s_tvalid & ~s_tready;

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (found) begin
                state_nxt = XFER;
            end
        end else begin
            if (accept && sel_last) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant_id <= grant_nxt;
            end
            if (accept && sel_last) begin
                last_grant <= grant_id;
            end
        end
    end

    // Output register: data only moves on a load, so it holds while the kernel stalls.
    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data;
            m_tkeep  <= sel_keep;
            m_tlast  <= sel_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef KERNEL_AXIS_ARB_WATCHDOG_EN
    localparam logic [15:0] LIMIT16 = 16'(WDOG_LIMIT);

    logic [15:0] wdog_cnt;

    // Counts granted-source starvation cycles; the grant itself is never revoked.
    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            wdog_cnt   <= '0;
            wdog_stall <= 1'b0;
        end else begin
            if ((state == IDLE && found) || accept) begin
                wdog_cnt <= '0;
            end else if (state == XFER && !sel_valid && wdog_cnt != 16'hFFFF) begin
                wdog_cnt <= wdog_cnt + 16'd1;
                if (wdog_cnt + 16'd1 >= LIMIT16) begin
                    wdog_stall <= 1'b1;
                end
            end
        end
    end
`else
    assign wdog_stall = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_axis_rr_arbiter.sv
// Scoreboard bench for kernel_axis_rr_arbiter: directed packets, monitor pops expected beats on handshake.
module tb_kernel_axis_rr_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int DATA_W     = 64;
    localparam int KW         = DATA_W / 8;
    localparam int WDOG_LIMIT = 8;
`ifdef KERNEL_AXIS_ARB_WATCHDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    typedef logic [DATA_W+KW:0] beat_t;

    logic                        kernel_monitor_clock = 1'b0;
    logic                        kernel_monitor_reset = 1'b1;
    logic [NUM_SRC*DATA_W-1:0]   s_tdata  = '0;
    logic [NUM_SRC*KW-1:0]       s_tkeep  = '0;
    logic [NUM_SRC-1:0]          s_tlast  = '0;
    logic [NUM_SRC-1:0]          s_tvalid = '0;
    logic [NUM_SRC-1:0]          s_tready;
    logic [DATA_W-1:0]           m_tdata;
    logic [KW-1:0]               m_tkeep;
    logic                        m_tlast;
    logic                        m_tvalid;
    logic                        m_tready = 1'b1;
    logic [1:0]                  grant_id;
    logic                        busy;
    logic [NUM_SRC-1:0]          src_block;
    logic                        wdog_stall;

    beat_t                       src_q[NUM_SRC][$];
    beat_t                       exp_q[$];
    logic [NUM_SRC-1:0]          hold = '0;
    logic [NUM_SRC-1:0]          fire = '0;
    int                          checks = 0;
    int                          errors = 0;

    kernel_axis_rr_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_W     (DATA_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .kernel_monitor_clock (kernel_monitor_clock),
        .kernel_monitor_reset (kernel_monitor_reset),
        .s_tdata              (s_tdata),
        .s_tkeep              (s_tkeep),
        .s_tlast              (s_tlast),
        .s_tvalid             (s_tvalid),
        .s_tready             (s_tready),
        .m_tdata              (m_tdata),
        .m_tkeep              (m_tkeep),
        .m_tlast              (m_tlast),
        .m_tvalid             (m_tvalid),
        .m_tready             (m_tready),
        .grant_id             (grant_id),
        .busy                 (busy),
        .src_block            (src_block),
        .wdog_stall           (wdog_stall)
    );

    always #5 kernel_monitor_clock = ~kernel_monitor_clock;

    function automatic logic [DATA_W-1:0] beat_data(input logic [7:0] tag, input int src, input int b);
        return {tag, 24'h00C0DE, 8'(src), 16'h0000, 8'(b)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                b = src_q[i][0];
                s_tvalid[i]                  = 1'b1;
                s_tdata[i*DATA_W +: DATA_W]  = b[DATA_W+KW:KW+1];
                s_tkeep[i*KW +: KW]          = b[KW:1];
                s_tlast[i]                   = b[0];
            end else begin
                s_tvalid[i]                  = 1'b0;
                s_tdata[i*DATA_W +: DATA_W]  = '0;
                s_tkeep[i*KW +: KW]          = '0;
                s_tlast[i]                   = 1'b0;
            end
        end
    endtask

    // Queues one packet on a source and records its beats as the next expected output.
    task automatic applyStimulus(input int src, input int nbeats, input logic [7:0] tag);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b = {beat_data(tag, src, k), (k == nbeats - 1) ? 8'h0F : 8'hFF, (k == nbeats - 1)};
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
        drive();
    endtask

    task automatic wait_mid();
        @(negedge kernel_monitor_clock);
        fire = s_tvalid & s_tready;
    endtask

    task automatic advance();
        @(posedge kernel_monitor_clock);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        fire = '0;
        drive();
    endtask

    task automatic step();
        wait_mid();
        advance();
    endtask

    task automatic drain(input string name);
        int n;
        logic pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 100) begin
            pending = busy || m_tvalid;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_q[i].size() > 0) begin
                    pending = 1'b1;
                end
            end
            if (pending) begin
                step();
                n++;
            end
        end
        checkOutput({name, "_drain_timeout"}, 64'(pending), 64'd0);
    endtask

    task automatic reset_dut();
        @(posedge kernel_monitor_clock);
        #1;
        kernel_monitor_reset = 1'b1;
        hold = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_q[i].delete();
        end
        m_tready = 1'b1;
        drive();
        repeat (2) @(posedge kernel_monitor_clock);
        #1;
        kernel_monitor_reset = 1'b0;
    endtask

    // Scoreboard monitor: every output handshake must match the next expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge kernel_monitor_clock);
            if (!kernel_monitor_reset && m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL monitor_extra_beat actual=%0h expected=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tdata, m_tkeep, m_tlast} !== e) begin
                        errors++;
                        $display("[TB] FAIL monitor_beat actual=%0h/%0h/%0b expected=%0h/%0h/%0b",
                                 m_tdata, m_tkeep, m_tlast, e[DATA_W+KW:KW+1], e[KW:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1:0] rot_seq [6];
        logic       seen;

        // Reset values
        #2;
        checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_m_tdata", m_tdata, 64'd0);
        checkOutput("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_src_block", 64'(src_block), 64'd0);
        checkOutput("rst_wdog_stall", 64'(wdog_stall), 64'd0);
        @(posedge kernel_monitor_clock);
        #1;
        kernel_monitor_reset = 1'b0;

        $display("[TB] single source 3-beat packet");
        applyStimulus(2, 3, 8'h11);
        wait_mid();
        checkOutput("t1_idle_busy", 64'(busy), 64'd0);
        checkOutput("t1_idle_tready", 64'(s_tready), 64'd0);
        advance();
        wait_mid();
        checkOutput("t1_grant", 64'(grant_id), 64'd2);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_tready", 64'(s_tready), 64'b0100);
        checkOutput("t1_mvalid_c1", 64'(m_tvalid), 64'd0);
        advance();
        wait_mid();
        checkOutput("t1_mvalid_c2", 64'(m_tvalid), 64'd1);
        checkOutput("t1_tlast_a", 64'(m_tlast), 64'd0);
        advance();
        step();
        wait_mid();
        checkOutput("t1_busy_after_c", 64'(busy), 64'd0);
        checkOutput("t1_tlast_c", 64'(m_tlast), 64'd1);
        checkOutput("t1_tkeep_c", 64'(m_tkeep), 64'h0F);
        advance();
        wait_mid();
        checkOutput("t1_mvalid_end", 64'(m_tvalid), 64'd0);
        advance();

        $display("[TB] contention sources 0 and 3");
        reset_dut();
        applyStimulus(0, 2, 8'h22);
        applyStimulus(3, 2, 8'h23);
        step();
        wait_mid();
        checkOutput("t2_grant0", 64'(grant_id), 64'd0);
        checkOutput("t2_tready0", 64'(s_tready), 64'b0001);
        checkOutput("t2_src_block", 64'(src_block), 64'b1000);
        advance();
        step();
        wait_mid();
        checkOutput("t2_bubble_busy", 64'(busy), 64'd0);
        checkOutput("t2_bubble_tready", 64'(s_tready), 64'd0);
        advance();
        wait_mid();
        checkOutput("t2_grant3", 64'(grant_id), 64'd3);
        checkOutput("t2_tready3", 64'(s_tready), 64'b1000);
        checkOutput("t2_bubble_out", 64'(m_tvalid), 64'd0);
        advance();
        drain("t2");

        $display("[TB] rotation with 1-beat packets");
        rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int p = 0; p < 6; p++) begin
            applyStimulus(int'(rot_seq[p]), 1, 8'h30 + 8'(p));
        end
        for (int p = 0; p < 6; p++) begin
            seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                wait_mid();
                if (busy) begin
                    seen = 1'b1;
                    checkOutput("t3_rotation_grant", 64'(grant_id), 64'(rot_seq[p]));
                end
                advance();
            end
            checkOutput("t3_rotation_seen", 64'(seen), 64'd1);
        end
        drain("t3");

        $display("[TB] backpressure mid-packet");
        applyStimulus(1, 4, 8'h44);
        step();
        step();
        step();
        m_tready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            wait_mid();
            checkOutput("t4_hold_data", m_tdata, beat_data(8'h44, 1, 1));
            checkOutput("t4_hold_valid", 64'(m_tvalid), 64'd1);
            checkOutput("t4_tready_low", 64'(s_tready), 64'd0);
            checkOutput("t4_src_block", 64'(src_block), 64'b0010);
            advance();
        end
        m_tready = 1'b1;
        drain("t4");

        $display("[TB] reset mid-packet");
        applyStimulus(2, 4, 8'h55);
        repeat (4) step();
        checkOutput("t5_pre_mvalid", 64'(m_tvalid), 64'd1);
        checkOutput("t5_pending_beats", 64'(exp_q.size()), 64'd2);
        kernel_monitor_reset = 1'b1;
        #1;
        checkOutput("t5_async_mvalid", 64'(m_tvalid), 64'd0);
        checkOutput("t5_async_busy", 64'(busy), 64'd0);
        checkOutput("t5_async_tready", 64'(s_tready), 64'd0);
        exp_q.delete();
        reset_dut();
        applyStimulus(0, 1, 8'h56);
        applyStimulus(3, 1, 8'h57);
        step();
        wait_mid();
        checkOutput("t5_first_grant", 64'(grant_id), 64'd0);
        advance();
        drain("t5");

        $display("[TB] watchdog stall");
        applyStimulus(2, 3, 8'h66);
        step();
        step();
        hold[2] = 1'b1;
        drive();
        for (int n = 0; n < 10; n++) begin
            wait_mid();
            checkOutput("t6_stall", 64'(wdog_stall), 64'(WDOG_ON && n >= 8));
            checkOutput("t6_grant_held", 64'(busy && grant_id == 2'd2), 64'd1);
            advance();
        end
        hold[2] = 1'b0;
        drive();
        drain("t6");
        checkOutput("t6_stall_sticky", 64'(wdog_stall), 64'(WDOG_ON));

        checkOutput("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
